// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B4 pipelined arbiter.
//
// Shares one slave bus between master 0 (UART debug bridge) and master 1
// (CPU or DMA). Ownership lasts for a whole bus cycle (owner CYC high).
// The arbiter tracks accepted-but-unacked requests to cap pipelining depth.
// A watchdog flushes a hung slave by synthesizing acks toward the owner.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m0_* / m1_*         master-side Wishbone (cyc/stb/we/adr/dat in; dat/ack/stall out)
//   s_*                 slave-side Wishbone (cyc/stb/we/adr/dat out; dat/ack/stall in)
//   grant_o             registered one-hot owner (01 = m0, 10 = m1, 00 = none)
//   timeout_o           registered one-cycle pulse when the watchdog fires
//
// Bus-side outputs are combinational muxes of the owner's signals, as the
// pipelined Wishbone handshake requires; grant_o and timeout_o are registered.
module wb_arbiter_2m #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MAX_OUT    = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_stall_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_stall_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_stall_i,

    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned WD_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic             WD_EN    = (TIMEOUT != 0);
    localparam logic             PRIO_M0  = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // owner encoding: 0 = m0, 1 = m1
    state_t             state_q,      state_d;
    logic               owner_q,      owner_d;
    logic               last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   out_cnt_q,    out_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q,     wd_cnt_d;
    logic [1:0]         grant_q,      grant_d;
    logic               timeout_q,    timeout_d;

    // Owner-selected master signals
    logic               own_cyc;
    logic               own_stb;
    logic               own_we;
    logic [AW-1:0]      own_adr;
    logic [DW-1:0]      own_wdat;

    // Owner-directed response, fanned out to the owning master only
    logic               own_ack;
    logic               own_stall;
    logic [DW-1:0]      own_rdat;

    logic               pick;
    logic               accept;
    logic               ack_valid;
    logic               expire;
    logic               cnt_full;

    assign own_cyc  = owner_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb  = owner_q ? m1_stb_i : m0_stb_i;
    assign own_we   = owner_q ? m1_we_i  : m0_we_i;
    assign own_adr  = owner_q ? m1_adr_i : m0_adr_i;
    assign own_wdat = owner_q ? m1_dat_i : m0_dat_i;

    assign cnt_full  = (out_cnt_q >= CNT_MAX);
    // Acks with nothing outstanding are strays from abandoned cycles
    assign ack_valid = s_ack_i && (out_cnt_q != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            out_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            grant_q      <= 2'b00;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            out_cnt_q    <= out_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            grant_q      <= grant_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state, arbitration, tracker, watchdog and bus muxing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        out_cnt_d    = out_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        grant_d      = grant_q;
        timeout_d    = 1'b0;

        pick      = 1'b0;
        accept    = 1'b0;
        expire    = 1'b0;

        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        own_ack   = 1'b0;
        own_stall = 1'b1;
        own_rdat  = '0;

        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    pick = PRIO_M0 ? 1'b0 : ~last_owner_q;
                end else begin
                    pick = m1_cyc_i;
                end
                if (m0_cyc_i || m1_cyc_i) begin
                    owner_d      = pick;
                    last_owner_d = pick;
                    grant_d      = pick ? 2'b10 : 2'b01;
                    out_cnt_d    = '0;
                    wd_cnt_d     = '0;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                s_cyc_o   = own_cyc;
                s_stb_o   = own_stb && !cnt_full;
                s_we_o    = own_we;
                s_adr_o   = own_adr;
                s_dat_o   = own_wdat;
                own_ack   = ack_valid;
                own_rdat  = s_dat_i;
                own_stall = s_stall_i || cnt_full;

                accept = s_stb_o && !s_stall_i;
                if (accept && !ack_valid) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end else if (!accept && ack_valid) begin
                    out_cnt_d = out_cnt_q - CNT_W'(1);
                end

                // Count idle cycles while the slave owes us acks; saturate
                if ((out_cnt_q != '0) && !s_ack_i) begin
                    if (wd_cnt_q != '1) begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
                end else begin
                    wd_cnt_d = '0;
                end
                expire = WD_EN && (out_cnt_q != '0) && !s_ack_i
                         && (wd_cnt_q == WD_LIMIT);

                if (!own_cyc) begin
                    // Owner released: outstanding work is abandoned
                    state_d   = ST_IDLE;
                    grant_d   = 2'b00;
                    out_cnt_d = '0;
                    wd_cnt_d  = '0;
                end else if (expire) begin
                    state_d   = ST_FLUSH;
                    timeout_d = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Slave side is quiet; one synthetic ack per outstanding request
                if (!own_cyc) begin
                    state_d   = ST_IDLE;
                    grant_d   = 2'b00;
                    out_cnt_d = '0;
                    wd_cnt_d  = '0;
                end else begin
                    own_ack = (out_cnt_q != '0);
                    if (out_cnt_q != '0) begin
                        out_cnt_d = out_cnt_q - CNT_W'(1);
                    end
                    if (out_cnt_q <= CNT_W'(1)) begin
                        wd_cnt_d = '0;
                        state_d  = ST_BUSY;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                grant_d   = 2'b00;
                out_cnt_d = '0;
                wd_cnt_d  = '0;
            end
        endcase
    end

    // Route the owner response; the non-owner is always stalled and silent
    always_comb begin
        m0_ack_o   = 1'b0;
        m0_stall_o = 1'b1;
        m0_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_stall_o = 1'b1;
        m1_dat_o   = '0;
        if (owner_q) begin
            m1_ack_o   = own_ack;
            m1_stall_o = own_stall;
            m1_dat_o   = own_rdat;
        end else begin
            m0_ack_o   = own_ack;
            m0_stall_o = own_stall;
            m0_dat_o   = own_rdat;
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m.
// u_rr: round-robin, MAX_OUT=4, TIMEOUT=8. u_fp: same but fixed priority,
// sharing every input so the tie sequence exercises both arbitration modes.
module tb_wb_arbiter_2m;

    logic        clk;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [15:0] m0_adr_i, m0_dat_i;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [15:0] m1_adr_i, m1_dat_i;
    logic [15:0] s_dat_i;
    logic        s_ack_i, s_stall_i;

    logic [15:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [15:0] s_adr_o, s_dat_o;
    logic [1:0]  grant_o;
    logic        timeout_o;

    logic [15:0] fp_m0_dat_o, fp_m1_dat_o;
    logic        fp_m0_ack_o, fp_m0_stall_o, fp_m1_ack_o, fp_m1_stall_o;
    logic        fp_s_cyc_o, fp_s_stb_o, fp_s_we_o;
    logic [15:0] fp_s_adr_o, fp_s_dat_o;
    logic [1:0]  fp_grant_o;
    logic        fp_timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter_2m #(.AW(16), .DW(16), .MAX_OUT(4), .TIMEOUT(8), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wb_arbiter_2m #(.AW(16), .DW(16), .MAX_OUT(4), .TIMEOUT(8), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(fp_m0_dat_o),
        .m0_ack_o(fp_m0_ack_o), .m0_stall_o(fp_m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(fp_m1_dat_o),
        .m1_ack_o(fp_m1_ack_o), .m1_stall_o(fp_m1_stall_o),
        .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o), .s_we_o(fp_s_we_o),
        .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_stall_i(s_stall_i),
        .grant_o(fp_grant_o), .timeout_o(fp_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_stall_i = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        // Reset state
        chk("rst_grant",    32'(grant_o), 0);
        chk("rst_s_cyc",    32'(s_cyc_o), 0);
        chk("rst_s_stb",    32'(s_stb_o), 0);
        chk("rst_s_we",     32'(s_we_o), 0);
        chk("rst_s_adr",    32'(s_adr_o), 0);
        chk("rst_m0_stall", 32'(m0_stall_o), 1);
        chk("rst_m1_stall", 32'(m1_stall_o), 1);
        chk("rst_m0_ack",   32'(m0_ack_o), 0);
        chk("rst_timeout",  32'(timeout_o), 0);
        cyc_next();
        cyc_next();
        rst = 1'b0;

        // Single owner write
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 16'h1234; m0_dat_i = 16'hBEEF;
        settle();
        chk("so_idle_grant", 32'(grant_o), 0);
        chk("so_idle_stall", 32'(m0_stall_o), 1);
        chk("so_idle_stb",   32'(s_stb_o), 0);
        cyc_next(); settle();
        chk("so_grant",    32'(grant_o), 32'h1);
        chk("so_s_cyc",    32'(s_cyc_o), 1);
        chk("so_s_stb",    32'(s_stb_o), 1);
        chk("so_s_we",     32'(s_we_o), 1);
        chk("so_s_adr",    32'(s_adr_o), 32'h1234);
        chk("so_s_dat",    32'(s_dat_o), 32'hBEEF);
        chk("so_m0_stall", 32'(m0_stall_o), 0);
        chk("so_m1_stall", 32'(m1_stall_o), 1);
        cyc_next();
        m0_stb_i = 0; s_ack_i = 1; s_dat_i = 16'h5A5A;
        settle();
        chk("so_m0_ack",    32'(m0_ack_o), 1);
        chk("so_m0_rdat",   32'(m0_dat_o), 32'h5A5A);
        chk("so_m1_ack",    32'(m1_ack_o), 0);
        chk("so_m1_stall2", 32'(m1_stall_o), 1);
        cyc_next();
        s_ack_i = 0; m0_cyc_i = 0; m0_we_i = 0;
        settle();
        chk("so_ack_once", 32'(m0_ack_o), 0);
        chk("so_rel_cyc",  32'(s_cyc_o), 0);
        cyc_next(); settle();
        chk("so_idle_after", 32'(grant_o), 0);

        // Round-robin vs fixed-priority ties, 2 transfers per ownership
        rst = 1'b1; #1; rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            m0_cyc_i = 1; m1_cyc_i = 1; m0_stb_i = 1; m1_stb_i = 1; s_ack_i = 0;
            settle();
            chk("rr_bubble", 32'(grant_o), 0);
            chk("fp_bubble", 32'(fp_grant_o), 0);
            cyc_next(); settle();
            chk("rr_grant", 32'(grant_o), (r % 2 == 0) ? 32'h1 : 32'h2);
            chk("fp_grant", 32'(fp_grant_o), 32'h1);
            cyc_next();
            s_ack_i = 1;
            settle();
            chk("rr_ack1", 32'((r % 2 == 0) ? m0_ack_o : m1_ack_o), 1);
            chk("fp_ack1", 32'(fp_m0_ack_o), 1);
            cyc_next();
            m0_cyc_i = 0; m1_cyc_i = 0; m0_stb_i = 0; m1_stb_i = 0;
            settle();
            chk("rr_ack2", 32'((r % 2 == 0) ? m0_ack_o : m1_ack_o), 1);
            chk("rr_rel_cyc", 32'(s_cyc_o), 0);
            cyc_next();
        end
        s_ack_i = 0;

        // Outstanding limit on m1
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 16'h0100;
        settle();
        chk("ol_idle", 32'(grant_o), 0);
        for (int k = 0; k < 4; k++) begin
            cyc_next(); settle();
            chk("ol_stb_open", 32'(s_stb_o), 1);
            chk("ol_stall_open", 32'(m1_stall_o), 0);
        end
        cyc_next(); settle();
        chk("ol_full_stb",   32'(s_stb_o), 0);
        chk("ol_full_stall", 32'(m1_stall_o), 1);
        chk("ol_grant",      32'(grant_o), 32'h2);
        cyc_next(); s_ack_i = 1; settle();
        chk("ol_ack_full_stb", 32'(s_stb_o), 0);
        chk("ol_ack_fwd",      32'(m1_ack_o), 1);
        cyc_next(); s_ack_i = 0; settle();
        chk("ol_reopen_stb",   32'(s_stb_o), 1);
        chk("ol_reopen_stall", 32'(m1_stall_o), 0);
        cyc_next(); s_ack_i = 1; settle();
        chk("ol_refull_stb", 32'(s_stb_o), 0);
        chk("ol_refull_ack", 32'(m1_ack_o), 1);
        cyc_next(); settle();
        chk("ol_both_stb", 32'(s_stb_o), 1);
        chk("ol_both_ack", 32'(m1_ack_o), 1);
        cyc_next(); m1_stb_i = 0; settle();
        chk("ol_cnt3_stall", 32'(m1_stall_o), 0);
        chk("ol_drain1", 32'(m1_ack_o), 1);
        cyc_next(); settle();
        chk("ol_drain2", 32'(m1_ack_o), 1);
        cyc_next(); settle();
        chk("ol_drain3", 32'(m1_ack_o), 1);
        cyc_next(); settle();
        chk("ol_spurious", 32'(m1_ack_o), 0);
        cyc_next(); s_ack_i = 0; m1_cyc_i = 0; settle();
        cyc_next();

        // Watchdog flush: 2 reads, slave never acks
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 16'h0040; s_dat_i = 16'hAAAA;
        settle();
        cyc_next(); settle();
        chk("wd_grant", 32'(grant_o), 32'h1);
        chk("wd_acc1",  32'(s_stb_o), 1);
        cyc_next(); settle();
        chk("wd_acc2",  32'(s_stb_o), 1);
        cyc_next(); m0_stb_i = 0; settle();
        for (int k = 0; k < 7; k++) begin
            chk("wd_wait_to", 32'(timeout_o), 0);
            chk("wd_wait_cyc", 32'(s_cyc_o), 1);
            cyc_next(); settle();
        end
        chk("wd_pulse",     32'(timeout_o), 1);
        chk("wd_fl_cyc",    32'(s_cyc_o), 0);
        chk("wd_fl_stb",    32'(s_stb_o), 0);
        chk("wd_fl_ack1",   32'(m0_ack_o), 1);
        chk("wd_fl_dat1",   32'(m0_dat_o), 0);
        chk("wd_fl_stall",  32'(m0_stall_o), 1);
        cyc_next(); settle();
        chk("wd_pulse_end", 32'(timeout_o), 0);
        chk("wd_fl_ack2",   32'(m0_ack_o), 1);
        chk("wd_fl_dat2",   32'(m0_dat_o), 0);
        cyc_next(); settle();
        chk("wd_busy_cyc",  32'(s_cyc_o), 1);
        chk("wd_busy_ack",  32'(m0_ack_o), 0);
        chk("wd_busy_stall", 32'(m0_stall_o), 0);

        // Early release with 2 outstanding, then stray acks
        cyc_next(); m0_stb_i = 1; settle();
        chk("er_acc1", 32'(s_stb_o), 1);
        cyc_next(); settle();
        cyc_next(); m0_stb_i = 0; m0_cyc_i = 0; settle();
        chk("er_rel_cyc", 32'(s_cyc_o), 0);
        cyc_next(); s_ack_i = 1; settle();
        chk("er_idle",    32'(grant_o), 0);
        chk("er_m0_ack1", 32'(m0_ack_o), 0);
        chk("er_m1_ack1", 32'(m1_ack_o), 0);
        cyc_next(); settle();
        chk("er_m0_ack2", 32'(m0_ack_o), 0);
        chk("er_m1_ack2", 32'(m1_ack_o), 0);
        cyc_next(); s_ack_i = 0; m0_cyc_i = 1; settle();
        cyc_next(); s_ack_i = 1; settle();
        chk("er_regrant",  32'(grant_o), 32'h1);
        chk("er_cnt_zero", 32'(m0_ack_o), 0);

        // Async reset mid-BUSY with 3 outstanding
        cyc_next(); s_ack_i = 0; m0_stb_i = 1; settle();
        cyc_next(); settle();
        cyc_next(); settle();
        cyc_next(); m0_stb_i = 0; settle();
        chk("ar_pre_cyc", 32'(s_cyc_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_s_cyc",    32'(s_cyc_o), 0);
        chk("ar_grant",    32'(grant_o), 0);
        chk("ar_m0_stall", 32'(m0_stall_o), 1);
        chk("ar_m1_stall", 32'(m1_stall_o), 1);
        cyc_next();
        cyc_next();
        rst = 1'b0; m0_cyc_i = 1; m1_cyc_i = 1;
        settle();
        chk("ar_idle", 32'(grant_o), 0);
        cyc_next(); settle();
        chk("ar_tie_m0", 32'(grant_o), 32'h1);

        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B4 pipelined arbiter with an outstanding-transaction tracker and a bus watchdog.
- Lets the UART debug bridge (uart2wb) and a second host (CPU or DMA) share one on-chip memory/peripheral bus.
- Sits between both masters and the slave interconnect.
- Ownership is held for a whole cycle (CYC assertion). A hung slave is recovered by synthesized acks.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_OUT, 4, maximum accepted-but-unacked requests per ownership; range 1..15.
- TIMEOUT, 255, cycles without ack while outstanding>0 before flush; 0 disables the watchdog.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request (debug bridge).
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  master 0 read data.
- m0_ack_o, m0_stall_o  out  1 each  master 0 response.
- m1_*  same set and widths as m0  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave request.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_stall_i  in  1 each  slave response.
- grant_o  out  2  one-hot current owner; 00 = none.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Clock, reset and state:
  - One clock domain. rst asynchronous, active-high.
  - Registered state: state, owner, last_owner, out_cnt (4b), wd_cnt (16b).
- Reset values:
  - state=IDLE, grant_o=00, out_cnt=0, wd_cnt=0, last_owner=m1 (so m0 wins the first round-robin tie), timeout_o=0.
  - Resulting outputs: s_cyc_o=s_stb_o=s_we_o=0, both m*_ack_o=0, both m*_stall_o=1, s_adr_o/s_dat_o/m*_dat_o=0.
- States: IDLE, BUSY, FLUSH.
- IDLE:
  - Nothing forwarded to the slave.
  - Requester = any master with cyc_i=1.
  - Only one requesting: it is granted.
  - Both requesting: FIXED_PRIO=1 grants m0; otherwise grant the master != last_owner.
  - On grant: owner/last_owner and grant_o register, then go to BUSY. Arbitration latency is 1 cycle; the owner's stb_i is ignored in the IDLE cycle (it sees stall_o=1).
- BUSY, owner muxing (combinational from owner):
  - s_cyc_o = owner cyc_i.
  - s_stb_o = owner stb_i & (out_cnt<MAX_OUT).
  - s_we_o, s_adr_o and s_dat_o follow the owner.
  - owner ack_o = s_ack_i; owner dat_o = s_dat_i.
  - owner stall_o = s_stall_i | (out_cnt==MAX_OUT).
  - Non-owner: stall_o=1, ack_o=0, dat_o=0.
- BUSY, outstanding count:
  - accept = s_stb_o & ~s_stall_i.
  - accept only: out_cnt+1. s_ack_i only: out_cnt-1. Both in the same cycle: unchanged.
  - s_ack_i with out_cnt==0 is a spurious ack: it is ignored, not forwarded, and out_cnt stays 0.
- BUSY, release:
  - Owner cyc_i=0 ends ownership: go to IDLE, grant_o=00, out_cnt cleared.
  - Abandoned transactions are dropped and any later stray acks are ignored.
  - A new grant needs one IDLE cycle, so there is one bubble cycle between owners.
- Watchdog:
  - In BUSY with out_cnt>0 and no s_ack_i, wd_cnt increments. Any ack or out_cnt==0 clears it.
  - When TIMEOUT!=0 and wd_cnt reaches TIMEOUT-1 with no ack that cycle: go to FLUSH and pulse timeout_o for 1 cycle.
- FLUSH:
  - s_cyc_o=s_stb_o=0; owner stall_o=1; slave acks ignored.
  - Each cycle: owner ack_o=1 with dat_o=0, and out_cnt decrements.
  - When out_cnt reaches 0 (after its last synthetic ack), wd_cnt clears. Then go to BUSY if owner cyc_i=1, else IDLE.
  - Owner drops cyc_i mid-FLUSH: go to IDLE immediately.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). The slave sees cyc drop in the same cycle.

Test Plan:
- Single owner:
  - Stimulus: m0 write adr 0x1234 dat 0xBEEF; slave acks 1 cycle after accept.
  - Required: grant_o=01 one cycle after m0_cyc_i; s_adr_o=0x1234, s_dat_o=0xBEEF; m0_ack_o=1 once; m1_stall_o=1 throughout.
- Round-robin tie:
  - Stimulus: m0 and m1 raise cyc in the same cycle, repeated 4 times, each ownership 2 transfers, FIXED_PRIO=0.
  - Required: grant order m0,m1,m0,m1 with exactly one IDLE bubble between owners.
  - Repeat with FIXED_PRIO=1. Required: always m0.
- Outstanding limit:
  - Stimulus: m1 issues 6 back-to-back reads; slave never stalls and withholds acks; MAX_OUT=4.
  - Required: s_stb_o accepted 4 times; m1_stall_o=1 once out_cnt=4. One ack reopens one slot; an ack and an accept in the same cycle leave out_cnt unchanged.
- Watchdog flush:
  - Stimulus: TIMEOUT=8; m0 issues 2 reads and the slave never acks.
  - Required: timeout_o pulses 8 cycles after the last accept; s_cyc_o=0; m0 gets 2 consecutive acks with dat_o=0x0000; return to BUSY.
- Early release and spurious ack:
  - Stimulus: m0 drops cyc with 2 outstanding, then the slave acks twice.
  - Required: IDLE next cycle, out_cnt=0, neither m*_ack_o asserted.
- Async reset:
  - Stimulus: rst asserted mid-BUSY with out_cnt=3.
  - Required: in the same cycle s_cyc_o=0, grant_o=00, both stall_o=1; after release, m0 wins the first tie.
